// File: rtl/ram_port_initiator.sv
// -----------------------------------------------------------------------------
// ram_port_initiator
//
// Drives one port of a synchronous read-first RAM from a valid/ready request
// stream. The read-first data of every accepted request comes back, in order,
// on a valid/ready response stream. A 3-entry response FIFO and credit gating
// absorb response backpressure, so the RAM port can run at one access per cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_*             request stream (valid/ready, byte enables, address, data)
//   resp_*            response stream (valid/ready, read-first data)
//   ram_*             RAM port (en, byte we, addr, wrdata, 1-cycle rddata)
//   init_done         block ready for traffic
//
// Optional feature macro: RAM_PORT_INITIATOR_CLEAR_EN
//   When defined, every reset is followed by a sweep that writes zero to each
//   RAM address. Requests are held off until the sweep finishes.
// -----------------------------------------------------------------------------
module ram_port_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wrdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rddata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wrdata,
  input  logic [DATA_WIDTH-1:0]   ram_rddata,
  output logic                    init_done
);

  localparam int BE_W = DATA_WIDTH / 8;

  // Circular pointer advance for the 3-entry FIFO (2 wraps to 0).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : (p + 2'd1);
  endfunction

  logic                  init_done_q;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [3];

  logic accept_s;
  logic push_s;
  logic pop_s;

`ifdef RAM_PORT_INITIATOR_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
`endif

  // Credits: the in-flight read plus buffered entries may never exceed the
  // FIFO depth, so a push can never hit a full FIFO. rst is folded in so no
  // handshake can be seen during the reset cycle.
  assign req_ready = init_done_q && !rst &&
                     (({2'b00, inflight_q} + {1'b0, count_q}) < 3'd3);
  assign accept_s  = req_valid && req_ready;

  assign resp_valid  = (count_q != 2'd0);
  assign resp_rddata = fifo_q[rd_ptr_q];
  assign init_done   = init_done_q;

  // The RAM returns data one cycle after ram_en; that is when it is captured.
  assign push_s = inflight_q;
  assign pop_s  = resp_valid && resp_ready;

  // RAM port drive: accepted request, or the clear sweep when enabled.
  always_comb begin
    ram_en     = accept_s;
    ram_we     = accept_s ? req_we : {BE_W{1'b0}};
    ram_addr   = req_addr;
    ram_wrdata = req_wrdata;
`ifdef RAM_PORT_INITIATOR_CLEAR_EN
    if ((state_q == ST_CLEAR) && !rst) begin
      ram_en     = 1'b1;
      ram_we     = {BE_W{1'b1}};
      ram_addr   = clr_addr_q;
      ram_wrdata = {DATA_WIDTH{1'b0}};
    end else begin
      ram_en     = accept_s;
    end
`endif
  end

  // Next-state for in-flight flag, FIFO occupancy and pointers.
  always_comb begin
    inflight_d = accept_s;
    wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset discards the in-flight read and buffered data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= ram_rddata;
    end
  end

`ifdef RAM_PORT_INITIATOR_CLEAR_EN
  // Init FSM: sweep every address once after reset, then run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= {ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end
`else
  // Ready for traffic from the first clock after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end
`endif

endmodule
